// File: rtl/cond_logic_pkg.sv
// Shared condition-code and flag definitions for the ARM condition stage.
// Imported by the condition checker, the flag stage and the decoder.
package cond_logic_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    CS = 4'h2,
    CC = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'ha,
    LT = 4'hb,
    GT = 4'hc,
    LE = 4'hd,
    AL = 4'he,
    NV = 4'hf
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagW[1] writes N,Z; FlagW[0] writes C,V.
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_logic_check.sv
// Combinational evaluation of a 4-bit condition field against NZCV.
// All 16 codes decode; NV behaviour is a parameter.
module cond_check
  import cond_logic_pkg::*;
#(
  parameter logic COND_NV_EXEC = 1'b1
) (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  logic ge;

  assign n  = flags[FLAG_N];
  assign z  = flags[FLAG_Z];
  assign c  = flags[FLAG_C];
  assign v  = flags[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    cond_ex = 1'b0;
    unique case (cond_t'(cond))
      EQ: cond_ex = z;
      NE: cond_ex = !z;
      CS: cond_ex = c;
      CC: cond_ex = !c;
      MI: cond_ex = n;
      PL: cond_ex = !n;
      VS: cond_ex = v;
      VC: cond_ex = !v;
      HI: cond_ex = c & !z;
      LS: cond_ex = !c | z;
      GE: cond_ex = ge;
      LT: cond_ex = !ge;
      GT: cond_ex = !z & ge;
      LE: cond_ex = z | !ge;
      AL: cond_ex = 1'b1;
      NV: cond_ex = COND_NV_EXEC;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Condition/flag stage after the ALU: NZCV register, registered
// execute decision and squashing of PC/register/memory writes.
module cond_logic
  import cond_logic_pkg::*;
#(
  parameter logic [3:0] FLAGS_RESET  = 4'b0000,
  parameter logic       COND_NV_EXEC = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       Stall,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic [1:0] nz_q, nz_d;
  logic [1:0] cv_q, cv_d;
  logic       cond_ex_reg_q, cond_ex_reg_d;

  assign Flags = {nz_q, cv_q};

  cond_check #(
    .COND_NV_EXEC(COND_NV_EXEC)
  ) u_cond_check (
    .cond   (Cond),
    .flags  (Flags),
    .cond_ex(CondEx)
  );

  // The writing instruction is judged against the old flags.
  always_comb begin
    nz_d          = nz_q;
    cv_d          = cv_q;
    cond_ex_reg_d = cond_ex_reg_q;
    if (!Stall) begin
      cond_ex_reg_d = CondEx;
      if (FlagW[FLAGW_NZ] && CondEx) nz_d = ALUFlags[3:2];
      if (FlagW[FLAGW_CV] && CondEx) cv_d = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nz_q <= FLAGS_RESET[3:2];
    end else begin
      nz_q <= nz_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cv_q <= FLAGS_RESET[1:0];
    end else begin
      cv_q <= cv_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_ex_reg_q <= 1'b0;
    end else begin
      cond_ex_reg_q <= cond_ex_reg_d;
    end
  end

  // Fetch increments are never squashed.
  assign PCWrite  = (PCS & cond_ex_reg_q) | NextPC;
  assign RegWrite = RegW & cond_ex_reg_q;
  assign MemWrite = MemW & cond_ex_reg_q;

endmodule
